adc_capture_buffer: RTL

Triggered capture buffer directly downstream of the serial ADC driver. Accepts the driver's 16-bit unsigned sample words, one per conversion strobe, keeps a circular history, and freezes a window of `DEPTH` samples around a level-crossing trigger, `PRE_TRIG` of them before the trigger. It then streams the window out over a valid/ready interface to the capture/readout logic.

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_capture_buffer_if.sv | 26 ++
 rtl/capture_ram.sv | 23 ++
 rtl/adc_capture_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types for the ADC capture buffer.
// One-hot FSM encoding and the default sample width.
package adc_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_PRE   = 5'b00010,
    S_ARMED = 5'b00100,
    S_POST  = 5'b01000,
    S_READ  = 5'b10000
  } state_t;

endpackage

// File: rtl/adc_capture_buffer_if.sv
// Readout stream of the ADC capture buffer.
// valid/ready handshake with an end-of-window marker.
interface adc_capture_buffer_if #(
  parameter int DATA_W = adc_pkg::DATA_W
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample store, one write port and
// a registered read port with one cycle of latency.
module capture_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rq
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rq <= mem[ra];
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered capture of ADC samples into a circular buffer,
// then readout of the frozen window over a valid/ready stream.
module adc_capture_buffer
  import adc_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = adc_pkg::DATA_W,
  parameter int PRE_TRIG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_falling,
  adc_capture_buffer_if.master out_bus,
  output logic              busy,
  output logic              triggered
);

  localparam int CW = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_A = ADDR_W'(PRE_TRIG);
  localparam logic [CW-1:0] PRE_N = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_N = CW'(DEPTH - PRE_TRIG);
  localparam logic [CW-1:0] LAST_N = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_N = CW'(1);

  state_t state;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] trig_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic [CW-1:0]     rd_cnt;
  logic [DATA_W-1:0] lvl;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] skid;
  logic              fall;
  logic              prev_ok;
  logic              hit;
  logic              we;
  logic              rd_en;
  logic              q_vld;
  logic              q_last;
  logic              tag_last;
  logic              skid_vld;
  logic              skid_last;
  logic              pop;
  logic              load_out;
  logic [1:0]        occ;

  assign we = in_valid &&
              (state inside {S_PRE, S_ARMED, S_POST});
  assign cnt_inc = cnt + 1'b1;

  assign hit = force_trig || (prev_ok && (fall ?
               (prev > lvl && in_data <= lvl) :
               (prev < lvl && in_data >= lvl)));

  assign pop = out_bus.out_valid && out_bus.out_ready;
  assign load_out = !out_bus.out_valid || pop;

  // words held in out reg, skid reg and the RAM read stage
  assign occ = {1'b0, out_bus.out_valid} +
               {1'b0, skid_vld} + {1'b0, q_vld};

  assign rd_en = (state == S_READ) &&
                 (rd_cnt != DEPTH_N) &&
                 ((occ - {1'b0, pop}) < 2'd2);

  assign tag_last = (rd_cnt == LAST_N);
  assign busy = (state != S_IDLE);

  capture_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk (clk),
    .we  (we),
    .wa  (wr_ptr),
    .wd  (in_data),
    .re  (rd_en),
    .ra  (rd_ptr),
    .rq  (q)
  );

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      trig_ptr  <= '0;
      cnt       <= '0;
      rd_cnt    <= '0;
      lvl       <= '0;
      prev      <= '0;
      fall      <= 1'b0;
      prev_ok   <= 1'b0;
      triggered <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr  <= wr_ptr + 1'b1;
        prev    <= in_data;
        prev_ok <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (arm) begin
            state   <= (PRE_TRIG == 0) ? S_ARMED : S_PRE;
            cnt     <= '0;
            lvl     <= trig_level;
            fall    <= trig_falling;
            prev_ok <= 1'b0;
          end
        end
        S_PRE: begin
          if (we) begin
            cnt <= cnt_inc;
            if (cnt_inc == PRE_N) state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (we && hit) begin
            trig_ptr  <= wr_ptr;
            cnt       <= ONE_N;
            triggered <= 1'b1;
            if (POST_N == ONE_N) begin
              state  <= S_READ;
              rd_ptr <= wr_ptr - PRE_A;
              rd_cnt <= '0;
            end else begin
              state <= S_POST;
            end
          end
        end
        S_POST: begin
          if (we) begin
            cnt <= cnt_inc;
            if (cnt_inc == POST_N) begin
              state  <= S_READ;
              rd_ptr <= trig_ptr - PRE_A;
              rd_cnt <= '0;
            end
          end
        end
        S_READ: begin
          if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_cnt <= rd_cnt + 1'b1;
          end
          if (pop && out_bus.out_last) begin
            state     <= S_IDLE;
            triggered <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // out reg refills from skid first so order is kept
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      q_vld             <= 1'b0;
      q_last            <= 1'b0;
      skid_vld          <= 1'b0;
      skid_last         <= 1'b0;
      skid              <= '0;
      out_bus.out_data  <= '0;
      out_bus.out_valid <= 1'b0;
      out_bus.out_last  <= 1'b0;
    end else begin
      q_vld  <= rd_en;
      q_last <= rd_en && tag_last;
      if (load_out) begin
        if (skid_vld) begin
          out_bus.out_data  <= skid;
          out_bus.out_last  <= skid_last;
          out_bus.out_valid <= 1'b1;
          skid_vld          <= q_vld;
          skid              <= q;
          skid_last         <= q_last;
        end else if (q_vld) begin
          out_bus.out_data  <= q;
          out_bus.out_last  <= q_last;
          out_bus.out_valid <= 1'b1;
        end else begin
          out_bus.out_valid <= 1'b0;
          out_bus.out_last  <= 1'b0;
        end
      end else if (q_vld) begin
        skid      <= q;
        skid_last <= q_last;
        skid_vld  <= 1'b1;
      end
    end
  end

endmodule
